adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one `adder_10bit` instance between NUM_REQ independent requesters.
- Each requester presents an operand pair through a valid/ready handshake. The arbiter grants one requester at a time in round-robin order and registers the operands.
- It computes the 11-bit sum on the shared adder and returns it with the requester ID over a valid/ready response channel.
- It sits between the client blocks and the single shared adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, at most one bit high.
- req_a  input  NUM_REQ*10  operand a, requester i in bits [10i+9:10i].
- req_b  input  NUM_REQ*10  operand b, same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  11  a+b of the granted request, bit 10 = carry out.
- rsp_id  output  ID_W  index of the requester that produced rsp_sum.
- busy  output  1  high whenever state != IDLE.
- op_count  output  16  completed responses, saturating at 16'hFFFF.

Behaviour:
- Reset (async assert, sync-released by the surrounding design) drives all of the following:
  - state=IDLE, rr_ptr=0.
  - Operand registers=0.
  - rsp_valid=0, rsp_sum=0, rsp_id=0.
  - req_ready=0, busy=0, op_count=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is combinational: one-hot on the winner, all zeros if no req_valid.
  - On the handshake (req_valid[w] & req_ready[w]):
    - Latch req_a/req_b slice w into op_a/op_b and w into id_q.
    - rr_ptr <= (w+1) mod NUM_REQ.
    - Next state = CALC.
- CALC:
  - The shared adder sees op_a/op_b.
  - Its 11-bit output is registered into rsp_sum, id_q into rsp_id, rsp_valid<=1.
  - Next state = RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id hold stable until accepted.
  - On rsp_valid & rsp_ready: rsp_valid<=0, op_count increments (no change at 16'hFFFF), next state = IDLE.
  - req_ready = 0.
- Latency:
  - Handshake at edge t -> rsp_valid high after edge t+1.
  - Earliest next grant is in the cycle after rsp acceptance, so minimum issue interval = 3 cycles with rsp_ready held high.
- Arithmetic:
  - Unsigned 10-bit + 10-bit, full 11-bit result, no truncation.
  - 10'h3FF+10'h3FF = 11'h7FE.
  - The adder has no carry-in; it is tied 0.
- Boundary conditions:
  - Requester drops req_valid in IDLE before the handshake: no grant, no state change, rr_ptr unchanged.
  - Request arriving during CALC/RESP: held off with req_ready=0; requester must keep valid and data stable.
  - Only the ready-to-winner path is combinational; req_ready never depends on rsp_ready.
  - rsp_ready low indefinitely: stays in RESP, outputs stable, no new grants.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Single active requester is re-granted every round.
  - Reset asserted mid-operation: in-flight operand and result are discarded, rsp_valid drops immediately (async), op_count clears.
- Assertions for verification:
  - $onehot0(req_ready).
  - rsp_sum/rsp_id stable while rsp_valid & !rsp_ready.
  - req_ready==0 when state!=IDLE.

Test Plan:
- Single request: req_valid=4'b0001, a=10'd5, b=10'd7, rsp_ready=1 -> req_ready[0] high in IDLE, rsp_valid after 2 edges with rsp_sum=11'd12, rsp_id=0, op_count=1.
- Carry out: a=10'h3FF, b=10'h001 on requester 2 -> rsp_sum=11'h400, rsp_id=2; a=b=10'h3FF -> 11'h7FE.
- Round robin: all four req_valid held high with distinct operands, rsp_ready=1:
  - grant order 0,1,2,3,0.
  - Responses spaced 3 cycles apart.
  - rsp_id sequence matches the grant order.
- Backpressure: rsp_ready=0 for 10 cycles while requester 1 valid:
  - rsp_sum/rsp_id stable, busy=1, req_ready=0 throughout.
  - After rsp_ready=1, the response completes and requester 1 is granted next cycle.
- Reset mid-op: assert rst_n=0 during CALC -> rsp_valid=0, busy=0, op_count=0 immediately; after release, the first grant goes to the lowest valid index starting from 0.
- Saturation: force 65535 completions (or preload via a bench shortcut) -> op_count stays 16'hFFFF on further responses.

Source files
------------

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//
// Purpose:
//   Shares a single 10-bit adder between NUM_REQ requesters. Requests are
//   granted one at a time in round-robin order, the chosen operands are
//   registered, the sum is computed on the shared adder and returned with
//   the requester index on a valid/ready response channel.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]     per-requester operand valid
//   req_ready  out  [NUM_REQ]     per-requester accept, at most one bit high
//   req_a      in   [NUM_REQ*10]  operand a, requester i in [10i+9:10i]
//   req_b      in   [NUM_REQ*10]  operand b, same packing as req_a
//   rsp_valid  out  result valid
//   rsp_ready  in   consumer accepts result
//   rsp_sum    out  [11]   a+b, bit 10 is the carry out
//   rsp_id     out  [ID_W] requester that produced rsp_sum
//   busy       out  high whenever the arbiter is not idle
//   op_count   out  [16]   completed responses, saturating at 16'hFFFF
//
// Also contains adder_10bit, the shared adder datapath.
// ---------------------------------------------------------------------------

module adder_10bit (
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    input  logic        cin,
    output logic [10:0] sum
);

    // Full-width unsigned add; operands are zero-extended so the carry
    // lands in bit 10.
    assign sum = {1'b0, a} + {1'b0, b} + {10'b0, cin};

endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*10-1:0] req_a,
    input  logic [NUM_REQ*10-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [10:0]           rsp_sum,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic            grant;
    logic [ID_W-1:0] id_q;
    logic [9:0]      op_a;
    logic [9:0]      op_b;
    logic [9:0]      sel_a;
    logic [9:0]      sel_b;
    logic [10:0]     add_sum;

    // Round-robin winner search. The outer loop matches the current
    // pointer value so every index below is a constant after unrolling.
    // Offsets are scanned from the far end back towards the pointer, so
    // the valid requester closest to rr_ptr is the last one written and
    // therefore wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (rr_ptr == ID_W'(p)) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    if (req_valid[(p + k) % NUM_REQ]) begin
                        win_found = 1'b1;
                        win_idx   = ID_W'((p + k) % NUM_REQ);
                    end
                end
            end
        end
    end

    // Operand mux: pick the winner's slice out of the packed buses.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_a = req_a[i*10 +: 10];
                sel_b = req_b[i*10 +: 10];
            end
        end
    end

    // The one shared adder; it only ever sees the registered operands and
    // has no carry-in.
    adder_10bit u_adder (
        .a   (op_a),
        .b   (op_b),
        .cin (1'b0),
        .sum (add_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant logic. req_ready is asserted only in IDLE and
    // depends on req_valid and rr_ptr alone, never on rsp_ready. Whenever
    // a winner exists it is also accepted, so grant marks the handshake.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant              = 1'b1;
                    next_state         = CALC;
                end
            end
            CALC: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. In IDLE a grant captures the operands and moves
    // the pointer past the winner (wrapping at NUM_REQ-1). CALC registers
    // the adder result. RESP holds everything until the consumer accepts,
    // then counts the completion, saturating at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                        id_q <= win_idx;
                        if (win_idx == ID_W'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= win_idx + 1'b1;
                        end
                    end
                end
                CALC: begin
                    rsp_sum   <= add_sum;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_count != 16'hFFFF) begin
                            op_count <= op_count + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // busy follows the state directly so it drops together with the
    // asynchronous reset.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
//
// Self-checking bench for adder_arbiter. Requesters are modelled as a set
// of pending operand pairs; a transaction-level reference picks the
// round-robin winner from the pending set and predicts the sum, id and
// completion count. Directed cases cover the listed scenarios, followed by
// randomized traffic with random response backpressure.
// ---------------------------------------------------------------------------

module tb_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*10-1:0] req_a;
    logic [NUM_REQ*10-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [10:0]           rsp_sum;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;
    logic [15:0]           op_count;

    adder_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;

    // Requester-side view: which requesters have a request outstanding and
    // with which operands.
    logic [NUM_REQ-1:0] pend;
    logic [9:0]         pendA [NUM_REQ];
    logic [9:0]         pendB [NUM_REQ];

    // Reference state: round-robin pointer and completion count.
    int rrModel;
    int modelCount;

    // Cycles at which rsp_valid was seen rising.
    int riseQ [$];

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive the requester buses from the pending set.
    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*10 +: 10]  = pendA[i];
            req_b[i*10 +: 10]  = pendB[i];
        end
    endtask

    function automatic int pickWinner(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [9:0] randOp();
        case ($urandom_range(0, 3))
            0:       return 10'h000;
            1:       return 10'h3FF;
            default: return 10'($urandom);
        endcase
    endfunction

    task automatic addRequest(input int i, input logic [9:0] a, input logic [9:0] b);
        pend[i]  = 1'b1;
        pendA[i] = a;
        pendB[i] = b;
    endtask

    // Continuous protocol monitor: at most one grant, no grant while busy,
    // response held stable under backpressure, and rsp_valid rise times.
    logic        holdPrev  = 1'b0;
    logic        validPrev = 1'b0;
    logic [10:0] sumPrev;
    logic [1:0]  idPrev;

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("onehot0_req_ready", 32'($onehot0(req_ready)), 32'd1);
            if (busy) checkOutput("req_ready_while_busy", 32'(req_ready), 32'd0);
            if (holdPrev && rsp_valid) begin
                checkOutput("rsp_sum_stable", 32'(rsp_sum), 32'(sumPrev));
                checkOutput("rsp_id_stable", 32'(rsp_id), 32'(idPrev));
            end
            if (rsp_valid && !validPrev) riseQ.push_back(cycleCount);
        end
        holdPrev  = rst_n && rsp_valid && !rsp_ready;
        validPrev = rst_n && rsp_valid;
        sumPrev   = rsp_sum;
        idPrev    = rsp_id;
    end

    // One complete transaction, entered and left at a negedge in IDLE.
    // holdCycles extra cycles of rsp_ready low; addMask requesters raise a
    // new request while the arbiter is busy.
    task automatic serveOne(input int holdCycles, input logic [NUM_REQ-1:0] addMask, output int observedId);
        int         w;
        logic [10:0] expSum;
        observedId = -1;
        w = pickWinner(pend, rrModel);
        if (w < 0) begin
            checkOutput("req_ready_no_request", 32'(req_ready), 32'd0);
            return;
        end
        checkOutput("req_ready_grant", 32'(req_ready), 32'(1 << w));
        checkOutput("busy_idle", 32'(busy), 32'd0);
        expSum = 11'(int'(pendA[w]) + int'(pendB[w]));
        rsp_ready = (holdCycles == 0);

        @(posedge clk);
        #1;
        pend[w] = 1'b0;
        applyStimulus();
        rrModel = (w + 1) % NUM_REQ;

        @(negedge clk);
        checkOutput("calc_busy", 32'(busy), 32'd1);
        checkOutput("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (addMask[i] && !pend[i]) addRequest(i, randOp(), randOp());
        end
        applyStimulus();

        @(negedge clk);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_sum", 32'(rsp_sum), 32'(expSum));
        checkOutput("rsp_id", 32'(rsp_id), 32'(w));
        observedId = int'(rsp_id);
        repeat (holdCycles) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rsp_sum", 32'(rsp_sum), 32'(expSum));
            checkOutput("hold_busy", 32'(busy), 32'd1);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;

        @(negedge clk);
        if (modelCount < 65535) modelCount++;
        checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("op_count", 32'(op_count), 32'(modelCount));
    endtask

    int id;
    int expOrder [5] = '{0, 1, 2, 3, 0};

    initial begin
        pend       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pendA[i] = '0;
            pendB[i] = '0;
        end
        rrModel    = 0;
        modelCount = 0;
        rsp_ready  = 1'b1;
        applyStimulus();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_op_count", 32'(op_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single request");
        addRequest(0, 10'd5, 10'd7);
        applyStimulus();
        #1;
        serveOne(0, '0, id);

        $display("[TB] carry out");
        addRequest(2, 10'h3FF, 10'h001);
        applyStimulus();
        #1;
        serveOne(0, '0, id);
        addRequest(3, 10'h3FF, 10'h3FF);
        applyStimulus();
        #1;
        serveOne(0, '0, id);

        $display("[TB] round robin");
        for (int i = 0; i < NUM_REQ; i++) addRequest(i, 10'(i * 100 + 1), 10'(i * 37 + 3));
        applyStimulus();
        #1;
        riseQ.delete();
        for (int k = 0; k < 5; k++) begin
            serveOne(0, '0, id);
            checkOutput("rr_order", 32'(id), 32'(expOrder[k]));
            if (k == 0) begin
                addRequest(0, 10'd999, 10'd24);
                applyStimulus();
                #1;
            end
        end
        checkOutput("rr_rsp_count", 32'(riseQ.size()), 32'd5);
        for (int k = 1; k < riseQ.size(); k++) begin
            checkOutput("rr_rsp_spacing", 32'(riseQ[k] - riseQ[k-1]), 32'd3);
        end

        $display("[TB] backpressure");
        addRequest(3, 10'd300, 10'd200);
        applyStimulus();
        #1;
        serveOne(10, 4'b0010, id);
        serveOne(0, '0, id);
        checkOutput("bp_next_grant", 32'(id), 32'd1);

        $display("[TB] request withdrawn before handshake");
        pend[0] = 1'b1;
        applyStimulus();
        #1;
        checkOutput("withdraw_ready_up", 32'(req_ready), 32'b0001);
        pend[0] = 1'b0;
        applyStimulus();
        #1;
        checkOutput("withdraw_ready_down", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("withdraw_busy", 32'(busy), 32'd0);
        addRequest(0, 10'd1, 10'd2);
        addRequest(1, 10'd3, 10'd4);
        applyStimulus();
        #1;
        serveOne(0, '0, id);
        serveOne(0, '0, id);

        $display("[TB] reset mid-operation");
        addRequest(2, 10'd77, 10'd88);
        applyStimulus();
        #1;
        @(posedge clk);
        #1;
        pend[2] = 1'b0;
        applyStimulus();
        @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rrModel    = 0;
        modelCount = 0;
        addRequest(1, 10'd10, 10'd20);
        addRequest(3, 10'd30, 10'd40);
        applyStimulus();
        #1;
        serveOne(0, '0, id);
        checkOutput("post_reset_first_grant", 32'(id), 32'd1);
        serveOne(0, '0, id);

        $display("[TB] op_count saturation");
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        #1;
        modelCount = 65534;
        checkOutput("op_count_preload", 32'(op_count), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            addRequest(0, randOp(), randOp());
            applyStimulus();
            #1;
            serveOne(0, '0, id);
        end
        checkOutput("op_count_saturated", 32'(op_count), 32'hFFFF);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) addRequest(i, randOp(), randOp());
            end
            if (pend == '0) addRequest($urandom_range(0, NUM_REQ - 1), randOp(), randOp());
            applyStimulus();
            #1;
            serveOne(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     NUM_REQ'($urandom), id);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
